// File: rtl/bfp_block_quantizer_pkg.sv
// Shared constants and types for the block-floating-point quantizer.
// Defines the default FP16 field widths, bit positions of the sign,
// exponent and mantissa fields, the block index width and the FSM states.
package bfp_block_quantizer_pkg;

  localparam int DEF_ELEMENT_SIZE  = 16;
  localparam int DEF_EXPONENT_SIZE = 5;
  localparam int DEF_MANTISSA_SIZE = 10;
  localparam int DEF_BLOCK_SIZE    = 4;

  localparam int SIGN_BIT = DEF_ELEMENT_SIZE - 1;
  localparam int EXP_MSB  = DEF_ELEMENT_SIZE - 2;
  localparam int EXP_LSB  = DEF_MANTISSA_SIZE;
  localparam int MANT_MSB = DEF_MANTISSA_SIZE - 1;
  localparam int MANT_LSB = 0;

  localparam int IDX_W = $clog2(DEF_BLOCK_SIZE);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/bfp_block_quantizer_if.sv
// Stream bundle between a producer of paired FP16 elements and the quantizer,
// plus the aligned output stream towards dot_product_top.
//   in_valid/in_ready/in_v1/in_v2      : input pair handshake and data
//   out_valid/out_v1/out_v2/out_last   : aligned pair stream (no backpressure)
// master = producer/consumer side (testbench), slave = the quantizer.
interface bfp_block_quantizer_if
  import bfp_block_quantizer_pkg::*;
#(
  parameter int ELEMENT_SIZE = DEF_ELEMENT_SIZE
);

  logic                    in_valid;
  logic                    in_ready;
  logic [ELEMENT_SIZE-1:0] in_v1;
  logic [ELEMENT_SIZE-1:0] in_v2;
  logic                    out_valid;
  logic                    out_last;
  logic [ELEMENT_SIZE-1:0] out_v1;
  logic [ELEMENT_SIZE-1:0] out_v2;

  modport master (
    output in_valid, in_v1, in_v2,
    input  in_ready, out_valid, out_last, out_v1, out_v2
  );

  modport slave (
    input  in_valid, in_v1, in_v2,
    output in_ready, out_valid, out_last, out_v1, out_v2
  );

endinterface

// File: rtl/bfp_block_quantizer_align_shift.sv
// Combinational alignment of one FP16 element to a shared block exponent.
//   elem       : input element {sign, exp, mant}
//   shared_exp : raw block-maximum exponent field of the lane
//   aligned    : {sign, shared_exp, truncated aligned mantissa}
// The mantissa is expressed as 0.m x 2^(shared-bias+1), so the hidden bit is
// kept by shifting one extra place; exponent 0 behaves as exponent 1 with no
// hidden bit, matching the FP16 subnormal encoding.
module bfp_block_quantizer_align_shift
  import bfp_block_quantizer_pkg::*;
#(
  parameter int ELEMENT_SIZE  = DEF_ELEMENT_SIZE,
  parameter int EXPONENT_SIZE = DEF_EXPONENT_SIZE,
  parameter int MANTISSA_SIZE = DEF_MANTISSA_SIZE
) (
  input  logic [ELEMENT_SIZE-1:0]  elem,
  input  logic [EXPONENT_SIZE-1:0] shared_exp,
  output logic [ELEMENT_SIZE-1:0]  aligned
);

  localparam int SW = EXPONENT_SIZE + 1;

  logic [EXPONENT_SIZE-1:0] elem_exp;
  logic [MANTISSA_SIZE-1:0] elem_mant;
  logic                     hidden;
  logic [SW-1:0]            e_eff;
  logic [SW-1:0]            s_eff;
  logic [SW-1:0]            shift;
  logic [MANTISSA_SIZE-1:0] mant_out;

  // Shift distance is (shared_eff - e_eff) + 1; the shared exponent is the
  // block maximum so the difference never goes negative. Large shifts simply
  // flush the mantissa to zero while the sign is still passed through.
  always_comb begin
    elem_exp  = elem[ELEMENT_SIZE-2 -: EXPONENT_SIZE];
    elem_mant = elem[MANTISSA_SIZE-1:0];
    hidden    = |elem_exp;
    e_eff     = (elem_exp == '0) ? SW'(1) : SW'(elem_exp);
    s_eff     = (shared_exp == '0) ? SW'(1) : SW'(shared_exp);
    shift     = s_eff - e_eff + SW'(1);
    mant_out  = MANTISSA_SIZE'({hidden, elem_mant} >> shift);
    aligned   = {elem[ELEMENT_SIZE-1], shared_exp, mant_out};
  end

endmodule

// File: rtl/bfp_block_quantizer.sv
// Block-floating-point quantizer feeding dot_product_top.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of bfp_block_quantizer_if
// Collects BLOCK_SIZE input pairs while tracking the per-lane maximum exponent,
// then replays the block for BLOCK_SIZE back-to-back cycles with every element
// aligned to its lane's shared exponent. Input is refused while replaying.
module bfp_block_quantizer
  import bfp_block_quantizer_pkg::*;
#(
  parameter int ELEMENT_SIZE  = DEF_ELEMENT_SIZE,
  parameter int EXPONENT_SIZE = DEF_EXPONENT_SIZE,
  parameter int MANTISSA_SIZE = DEF_MANTISSA_SIZE,
  parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE
) (
  input logic                  clk,
  input logic                  rst,
  bfp_block_quantizer_if.slave bus
);

  localparam int BLK_IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [BLK_IDX_W-1:0] LAST_IDX = BLK_IDX_W'(BLOCK_SIZE - 1);

  state_t                   state;
  logic [BLK_IDX_W-1:0]     idx;
  logic [BLK_IDX_W-1:0]     sel;
  logic [ELEMENT_SIZE-1:0]  lane1_mem [BLOCK_SIZE];
  logic [ELEMENT_SIZE-1:0]  lane2_mem [BLOCK_SIZE];
  logic [EXPONENT_SIZE-1:0] max1;
  logic [EXPONENT_SIZE-1:0] max2;
  logic [EXPONENT_SIZE-1:0] in_exp1;
  logic [EXPONENT_SIZE-1:0] in_exp2;
  logic [EXPONENT_SIZE-1:0] next_max1;
  logic [EXPONENT_SIZE-1:0] next_max2;
  logic [EXPONENT_SIZE-1:0] shared1;
  logic [EXPONENT_SIZE-1:0] shared2;
  logic [ELEMENT_SIZE-1:0]  aligned1;
  logic [ELEMENT_SIZE-1:0]  aligned2;
  logic                     accept;

  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic [ELEMENT_SIZE-1:0]  out_v1_q;
  logic [ELEMENT_SIZE-1:0]  out_v2_q;

  assign in_exp1 = bus.in_v1[ELEMENT_SIZE-2 -: EXPONENT_SIZE];
  assign in_exp2 = bus.in_v2[ELEMENT_SIZE-2 -: EXPONENT_SIZE];
  assign accept  = bus.in_valid & in_ready_q;

  // Select which buffered element gets loaded into the output registers at
  // the next edge. While collecting this is element 0 aligned against the
  // running maximum that already includes the incoming pair, so the first
  // output is ready the cycle right after the final accept. While emitting it
  // is the element after the one currently on the outputs.
  always_comb begin
    next_max1 = (in_exp1 > max1) ? in_exp1 : max1;
    next_max2 = (in_exp2 > max2) ? in_exp2 : max2;
    if (state == COLLECT) begin
      sel     = '0;
      shared1 = next_max1;
      shared2 = next_max2;
    end else begin
      sel     = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      shared1 = max1;
      shared2 = max2;
    end
  end

  bfp_block_quantizer_align_shift #(
    .ELEMENT_SIZE (ELEMENT_SIZE),
    .EXPONENT_SIZE(EXPONENT_SIZE),
    .MANTISSA_SIZE(MANTISSA_SIZE)
  ) u_align1 (
    .elem      (lane1_mem[sel]),
    .shared_exp(shared1),
    .aligned   (aligned1)
  );

  bfp_block_quantizer_align_shift #(
    .ELEMENT_SIZE (ELEMENT_SIZE),
    .EXPONENT_SIZE(EXPONENT_SIZE),
    .MANTISSA_SIZE(MANTISSA_SIZE)
  ) u_align2 (
    .elem      (lane2_mem[sel]),
    .shared_exp(shared2),
    .aligned   (aligned2)
  );

  // Collect/emit state machine with all handshake and data outputs registered.
  // In EMIT, idx names the element currently presented on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      idx         <= '0;
      max1        <= '0;
      max2        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_v1_q    <= '0;
      out_v2_q    <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        lane1_mem[i] <= '0;
        lane2_mem[i] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            lane1_mem[idx] <= bus.in_v1;
            lane2_mem[idx] <= bus.in_v2;
            max1           <= next_max1;
            max2           <= next_max2;
            if (idx == LAST_IDX) begin
              state       <= EMIT;
              idx         <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              out_v1_q    <= aligned1;
              out_v2_q    <= aligned2;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        EMIT: begin
          if (idx == LAST_IDX) begin
            state       <= COLLECT;
            idx         <= '0;
            max1        <= '0;
            max2        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_v1_q    <= '0;
            out_v2_q    <= '0;
          end else begin
            idx        <= sel;
            out_last_q <= (sel == LAST_IDX);
            out_v1_q   <= aligned1;
            out_v2_q   <= aligned2;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_v1    = out_v1_q;
  assign bus.out_v2    = out_v2_q;

endmodule

// File: tb/tb_bfp_block_quantizer.sv
// Testbench for bfp_block_quantizer: fixed vector table with hand-derived
// expected outputs, multi-cycle flow-control and reset sequences, and a
// randomized run checked cycle by cycle against a value-level reference model.
module tb_bfp_block_quantizer;
  import bfp_block_quantizer_pkg::*;

  localparam int BS = DEF_BLOCK_SIZE;

  typedef struct {
    logic        valid;
    logic        last;
    logic [15:0] v1;
    logic [15:0] v2;
  } out_t;

  typedef struct {
    string       name;
    logic [15:0] v1 [BS];
    logic [15:0] v2 [BS];
    logic [15:0] e1 [BS];
    logic [15:0] e2 [BS];
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bfp_block_quantizer_if #(.ELEMENT_SIZE(16)) bus ();

  bfp_block_quantizer #(
    .ELEMENT_SIZE (16),
    .EXPONENT_SIZE(5),
    .MANTISSA_SIZE(10),
    .BLOCK_SIZE   (BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  vec_t        tbl [5];
  out_t        cur;
  out_t        pend [$];
  out_t        obs [$];
  logic [15:0] blk1 [$];
  logic [15:0] blk2 [$];

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: actual %b required %b", name, cycle, act, req);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: actual %h required %h", name, cycle, act, req);
    end
  endtask

  // Reference alignment from the value definition: the element's magnitude
  // sig * 2^e_eff re-expressed in units of 2^(shared_eff+1), truncated.
  function automatic logic [15:0] refAlign(input logic [15:0] x, input int shared);
    int          e;
    int          e_eff;
    int          s_eff;
    longint      sig;
    longint      q;
    logic [4:0]  sh5;
    logic [9:0]  q10;
    e     = int'(x[EXP_MSB:EXP_LSB]);
    sig   = longint'(x[MANT_MSB:MANT_LSB]);
    if (e != 0) sig = sig + 1024;
    e_eff = (e == 0) ? 1 : e;
    s_eff = (shared == 0) ? 1 : shared;
    q     = (sig * (longint'(1) << e_eff)) / (longint'(1) << (s_eff + 1));
    sh5   = 5'(shared);
    q10   = 10'(q);
    return {x[SIGN_BIT], sh5, q10};
  endfunction

  task automatic buildBlock();
    int s1 = 0;
    int s2 = 0;
    for (int i = 0; i < BS; i++) begin
      if (int'(blk1[i][EXP_MSB:EXP_LSB]) > s1) s1 = int'(blk1[i][EXP_MSB:EXP_LSB]);
      if (int'(blk2[i][EXP_MSB:EXP_LSB]) > s2) s2 = int'(blk2[i][EXP_MSB:EXP_LSB]);
    end
    for (int i = 0; i < BS; i++)
      pend.push_back('{valid: 1'b1, last: (i == BS - 1),
                       v1: refAlign(blk1[i], s1), v2: refAlign(blk2[i], s2)});
  endtask

  // Model advance for one clock edge given the inputs driven in this cycle.
  task automatic modelUpdate(input logic vld, input logic [15:0] a, input logic [15:0] b,
                             input logic r);
    if (r) begin
      blk1.delete();
      blk2.delete();
      pend.delete();
      cur = '{valid: 1'b0, last: 1'b0, v1: 16'h0, v2: 16'h0};
      return;
    end
    if (vld && !cur.valid) begin
      blk1.push_back(a);
      blk2.push_back(b);
      if (blk1.size() == BS) begin
        buildBlock();
        blk1.delete();
        blk2.delete();
      end
    end
    if (pend.size() > 0) cur = pend.pop_front();
    else cur = '{valid: 1'b0, last: 1'b0, v1: 16'h0, v2: 16'h0};
  endtask

  task automatic checkOutput();
    check1("in_ready", bus.in_ready, !cur.valid);
    check1("out_valid", bus.out_valid, cur.valid);
    check1("out_last", bus.out_last, cur.valid && cur.last);
    if (cur.valid) begin
      check16("out_v1", bus.out_v1, cur.v1);
      check16("out_v2", bus.out_v2, cur.v2);
    end
    if (bus.out_valid === 1'b1)
      obs.push_back('{valid: 1'b1, last: bus.out_last, v1: bus.out_v1, v2: bus.out_v2});
  endtask

  task automatic applyStimulus(input logic vld, input logic [15:0] a, input logic [15:0] b,
                               input logic r);
    rst          = r;
    bus.in_valid = vld;
    bus.in_v1    = a;
    bus.in_v2    = b;
  endtask

  // One cycle: check what the DUT shows now, drive the next inputs, advance
  // the model, and move to the next falling edge.
  task automatic step(input logic vld, input logic [15:0] a, input logic [15:0] b,
                      input logic r);
    checkOutput();
    applyStimulus(vld, a, b, r);
    modelUpdate(vld, a, b, r);
    @(negedge clk);
    cycle++;
  endtask

  task automatic runCollect(input int t, input int gap_a, input int gap_b);
    int gap;
    for (int i = 0; i < BS; i++) begin
      gap = (i == 1) ? gap_a : ((i == 3) ? gap_b : 0);
      repeat (gap) step(1'b0, 16'($urandom), 16'($urandom), 1'b0);
      step(1'b1, tbl[t].v1[i], tbl[t].v2[i], 1'b0);
    end
  endtask

  task automatic drain(input logic hold);
    for (int k = 0; k < BS + 2 && cur.valid; k++)
      step(hold, 16'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic compareTable(input int t);
    checks++;
    if (obs.size() != BS) begin
      errors++;
      $display("[TB] FAIL %s count: actual %0d outputs required %0d", tbl[t].name, obs.size(), BS);
    end
    for (int i = 0; i < BS && i < obs.size(); i++) begin
      check16({tbl[t].name, "_v1"}, obs[i].v1, tbl[t].e1[i]);
      check16({tbl[t].name, "_v2"}, obs[i].v2, tbl[t].e2[i]);
      check1({tbl[t].name, "_last"}, obs[i].last, (i == BS - 1));
    end
    obs.delete();
  endtask

  function automatic logic [15:0] randElem();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(0, 1) == 1) x[EXP_MSB:EXP_LSB] = 5'($urandom_range(8, 13));
    return x;
  endfunction

  initial begin
    tbl[0].name = "uniform";
    tbl[0].v1 = '{16'h1280, 16'h1280, 16'h1280, 16'h1280};
    tbl[0].v2 = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    tbl[0].e1 = '{16'h1340, 16'h1340, 16'h1340, 16'h1340};
    tbl[0].e2 = '{16'h1200, 16'h1200, 16'h1200, 16'h1200};
    tbl[1].name = "mixed";
    tbl[1].v1 = '{16'h1000, 16'h1800, 16'h1000, 16'h1800};
    tbl[1].v2 = '{16'h2400, 16'h0C00, 16'h8800, 16'h3C01};
    tbl[1].e1 = '{16'h1880, 16'h1A00, 16'h1880, 16'h1A00};
    tbl[1].e2 = '{16'h3C08, 16'h3C00, 16'hBC00, 16'h3E00};
    tbl[2].name = "underflow";
    tbl[2].v1 = '{16'h5000, 16'h9000, 16'h5000, 16'h5000};
    tbl[2].v2 = '{16'h0001, 16'h03FF, 16'h8200, 16'h0000};
    tbl[2].e1 = '{16'h5200, 16'hD000, 16'h5200, 16'h5200};
    tbl[2].e2 = '{16'h0000, 16'h01FF, 16'h8100, 16'h0000};
    tbl[3].name = "allzero";
    tbl[3].v1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[3].v2 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[3].e1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[3].e2 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4].name = "exp31";
    tbl[4].v1 = '{16'h7C00, 16'h0400, 16'hFFFF, 16'h7BFF};
    tbl[4].v2 = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    tbl[4].e1 = '{16'h7E00, 16'h7C00, 16'hFFFF, 16'h7DFF};
    tbl[4].e2 = '{16'h4200, 16'h4200, 16'h4200, 16'h4200};

    cur = '{valid: 1'b0, last: 1'b0, v1: 16'h0, v2: 16'h0};
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    repeat (2) @(negedge clk);

    check1("reset_in_ready", bus.in_ready, 1'b1);
    check1("reset_out_valid", bus.out_valid, 1'b0);
    check1("reset_out_last", bus.out_last, 1'b0);
    check16("reset_out_v1", bus.out_v1, 16'h0000);
    check16("reset_out_v2", bus.out_v2, 16'h0000);

    for (int t = 0; t < 5; t++) begin
      runCollect(t, 0, 0);
      drain(1'b0);
      compareTable(t);
    end

    $display("[TB] gaps in in_valid and in_valid held during emit");
    runCollect(1, 3, 2);
    drain(1'b1);
    compareTable(1);
    runCollect(0, 0, 0);
    drain(1'b0);
    compareTable(0);

    $display("[TB] reset after two accepted pairs");
    step(1'b1, tbl[2].v1[0], tbl[2].v2[0], 1'b0);
    step(1'b1, tbl[2].v1[1], tbl[2].v2[1], 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    check16("abort_collect_v1", bus.out_v1, 16'h0000);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    runCollect(0, 0, 0);
    drain(1'b0);
    compareTable(0);

    $display("[TB] reset during second emit cycle");
    runCollect(3, 0, 0);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    check1("abort_emit_valid", bus.out_valid, 1'b0);
    check1("abort_emit_ready", bus.in_ready, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    obs.delete();
    runCollect(4, 0, 0);
    drain(1'b0);
    compareTable(4);

    $display("[TB] randomized stream against reference model");
    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 3) != 0, randElem(), randElem(), $urandom_range(0, 199) == 0);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    obs.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfp_block_quantizer.md
Name: bfp_block_quantizer

Overview:
- Upstream of dot_product_top: converts paired FP16 streams (v1, v2) into block-floating-point blocks of BLOCK_SIZE elements.
- Each lane gets its own shared exponent, equal to the lane's block maximum.
- Buffers one block per lane, then replays aligned elements back-to-back with out_valid driving dot_product_top's enable.

Parameters:
- ELEMENT_SIZE, 16, element width = 1 sign + EXPONENT_SIZE + MANTISSA_SIZE
- EXPONENT_SIZE, 5, exponent field width
- MANTISSA_SIZE, 10, mantissa field width
- BLOCK_SIZE, 4, elements per block (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept input this cycle
- in_v1  in  ELEMENT_SIZE  lane-1 FP16 element {sign, exp, mant}
- in_v2  in  ELEMENT_SIZE  lane-2 FP16 element
- out_valid  out  1  aligned pair valid; connects to dot_product_top enable
- out_v1  out  ELEMENT_SIZE  {sign, shared_exp1, aligned_mant}
- out_v2  out  ELEMENT_SIZE  {sign, shared_exp2, aligned_mant}
- out_last  out  1  high with the final pair of a block

Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, out_last=0, out_v1=out_v2=0.
  - Counters, max exponents and buffer are cleared; FSM goes to COLLECT.
- FSM states:
  - COLLECT:
    - in_ready=1; a pair is accepted when in_valid&in_ready at a clk edge.
    - Each accepted pair is written to buffer[idx]; idx increments.
    - Per-lane running max of the raw exponent field is updated, including the current element.
    - On accepting pair BLOCK_SIZE-1, go to EMIT and clear idx.
  - EMIT:
    - in_ready=0; in_valid is ignored and no data is captured.
    - out_valid=1 for exactly BLOCK_SIZE consecutive cycles, element idx per cycle, in arrival order.
    - out_last=1 on idx=BLOCK_SIZE-1.
    - Next cycle returns to COLLECT with max exponents reset to 0.
- Latency: first out_valid occurs in the cycle after the last input pair is accepted (registered outputs).
- No output backpressure: dot_product_top consumes one pair per cycle while enabled.
- Throughput: one block per 2×BLOCK_SIZE cycles at best.
- Gaps in in_valid during COLLECT simply stall collection; partial blocks wait indefinitely.
- Alignment, per element, lane independent:
  - hidden = (exp≠0); e_eff = (exp==0) ? 1 : exp.
  - shared = max exponent field of the block; if the block max is 0, shared_eff = 1 for the shift calculation.
  - d = shared_eff − e_eff.
  - aligned_mant = ({hidden, mant} >> (d+1))[MANTISSA_SIZE-1:0]; value is 0.aligned_mant × 2^(shared−bias+1).
  - Truncation only (round toward zero); d+1 ≥ MANTISSA_SIZE+1 yields 0.
  - Output sign = input sign, including when aligned_mant is 0.
  - Output exponent field = shared (raw, not shared_eff).
- Exponent 31 (Inf/NaN encodings) gets no special treatment; it is an ordinary field value.
- Reset during COLLECT or EMIT aborts the block: outputs are low the next cycle and the partial block is discarded.

Decomposition:
- Package bfp_pkg:
  - ELEMENT_SIZE/EXPONENT_SIZE/MANTISSA_SIZE defaults.
  - Field-position constants SIGN_BIT, EXP_MSB/LSB, MANT_MSB/LSB.
  - IDX_W = $clog2(BLOCK_SIZE).
  - FSM state encoding (COLLECT, EMIT).
- Sub-module bfp_align_shift: combinational; inputs element + shared exponent, output aligned element. Instantiated once per lane, operating on the buffer entry selected by idx.

Test Plan:
- Uniform exponent: 4 pairs of in_v1=0x1280 (exp 4, mant 0x280), in_v2=0x1000 → 4 output cycles after the last accept, out_v1=0x1340, out_v2=0x1200, out_last on 4th.
- Mixed exponents, lane 1 = {0x1000, 0x1800, 0x1000, 0x1800} → shared 6, out_v1 = {0x1880, 0x1A00, 0x1880, 0x1A00}; lane 2 checked independently with a different max.
- Underflow to zero:
  - Lane 1 = {0x5000, 0x9000, 0x5000, 0x5000}; 0x9000 has d=16.
  - Expect out_v1 = {0x5200, 0xD000, 0x5200, 0x5200}; sign kept on the zero mantissa.
- All-zero block → outputs 0x0000 ×4, out_valid still asserted 4 cycles.
- Flow control:
  - Drop in_valid for 3 cycles mid-COLLECT, then 2 cycles → outputs are unchanged.
  - in_valid held high during EMIT with in_ready=0 → no capture; the next block is unaffected.
- Reset: assert rst after 2 accepted pairs, and separately during the 2nd EMIT cycle → out_valid=0 next cycle, in_ready=1; a fresh full block afterwards produces correct results with no residue.
